id_decode_mt: RTL and testbench

ID_DECODE_MT -- requirements
Module: id_decode_mt

---
 rtl/id_decode_mt_pkg.sv | 43 ++++
 rtl/id_decode_mt_if.sv | 58 +++++
 rtl/id_decode_mt_regfile.sv | 47 ++++
 rtl/id_decode_mt.sv | 149 ++++++++++++++
 tb/tb_id_decode_mt.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_decode_mt_pkg.sv
// Shared types and helpers for the multithreaded decode stage: command
// classes, the opcodes that drive them, and small decode predicates.
package id_mt_pkg;

    // Coarse instruction class handed to the execute stage
    typedef enum logic [1:0] {
        MEM    = 2'b00,
        ALU    = 2'b01,
        BRANCH = 2'b10,
        OTHER  = 2'b11
    } cmd_type_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Thread-id width; a single-thread build still carries a 1-bit id
    function automatic int tid_width(input int num_threads);
        return (num_threads > 1) ? $clog2(num_threads) : 1;
    endfunction

    function automatic cmd_type_e decode_cmd(input logic [6:0] opcode);
        case (opcode)
            OP_BRANCH:          return BRANCH;
            OP_ALU_R, OP_ALU_I: return ALU;
            OP_LOAD, OP_STORE:  return MEM;
            default:            return OTHER;
        endcase
    endfunction

    // Instructions whose result comes back later through writeback
    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode == OP_ALU_R) || (opcode == OP_ALU_I) || (opcode == OP_LOAD);
    endfunction

    // Instructions that genuinely consume rs2
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_ALU_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_decode_mt_if.sv
// Fetch, writeback and execute-side signals of the decode stage.
// slave is the decoder's view, master the surrounding pipeline's view.
interface id_decode_mt_if
    import id_mt_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_THREADS = 4
);
    localparam int TID_W = tid_width(NUM_THREADS);

    // fetch side
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic [TID_W-1:0] in_tid;

    // writeback
    logic             wb_alu_en;
    logic             wb_mem_en;
    logic [XLEN-1:0]  wb_alu_data;
    logic [XLEN-1:0]  wb_lmd_data;
    logic [4:0]       wb_rd;
    logic [TID_W-1:0] wb_tid;

    // execute side
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_opcode;
    cmd_type_e        out_cmd_type;
    logic [4:0]       out_rd;
    logic [TID_W-1:0] out_tid;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_imm_alu;
    logic [XLEN-1:0]  out_rs1_data;
    logic [XLEN-1:0]  out_rs2_data;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;

    modport slave (
        input  in_valid, in_instr, in_pc, in_tid,
        input  wb_alu_en, wb_mem_en, wb_alu_data, wb_lmd_data, wb_rd, wb_tid,
        input  out_ready,
        output in_ready,
        output out_valid, out_opcode, out_cmd_type, out_rd, out_tid,
        output out_imm, out_imm_alu, out_rs1_data, out_rs2_data, out_pc, out_instr
    );

    modport master (
        output in_valid, in_instr, in_pc, in_tid,
        output wb_alu_en, wb_mem_en, wb_alu_data, wb_lmd_data, wb_rd, wb_tid,
        output out_ready,
        input  in_ready,
        input  out_valid, out_opcode, out_cmd_type, out_rd, out_tid,
        input  out_imm, out_imm_alu, out_rs1_data, out_rs2_data, out_pc, out_instr
    );

endinterface

// File: rtl/id_decode_mt_regfile.sv
// Per-thread integer register files: one write port, two read ports with
// same-cycle write-to-read bypass, x0 hard-wired to zero.
module id_mt_regfile #(
    parameter int XLEN        = 32,
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [TID_W-1:0] wtid,
    input  logic [4:0]       wrd,
    input  logic [XLEN-1:0]  wdata,
    input  logic [TID_W-1:0] rtid,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [XLEN-1:0]  rd1,
    output logic [XLEN-1:0]  rd2
);

    logic [XLEN-1:0] regs [NUM_THREADS][32];

    // Register write; every architectural register clears on reset
    // NOTE: this array is reset element by element, so it maps to flops
    // rather than a RAM macro; that is what lets reset zero every thread.
    // NOTE: sequential state uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int r = 0; r < 32; r++) begin
                    regs[t][r] <= '0;
                end
            end
        end else if (we && (wrd != 5'd0)) begin
            regs[wtid][wrd] <= wdata;
        end
    end

    assign rd1 = (ra1 == 5'd0)                            ? '0    :
                 (we && (wtid == rtid) && (wrd == ra1))   ? wdata :
                                                            regs[rtid][ra1];

    assign rd2 = (ra2 == 5'd0)                            ? '0    :
                 (we && (wtid == rtid) && (wrd == ra2))   ? wdata :
                                                            regs[rtid][ra2];

endmodule

// File: rtl/id_decode_mt.sv
// Multithreaded instruction decode: field extraction, register read with
// writeback bypass, per-thread busy-bit scoreboard and a one-deep output
// register toward execute.
module id_decode_mt
    import id_mt_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_THREADS = 4
) (
    input logic           clk,
    input logic           rst,
    id_decode_mt_if.slave bus
);

    localparam int TID_W = tid_width(NUM_THREADS);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    cmd_type_e       cmd;
    logic            wb_fire;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic            rs1_hz;
    logic            rs2_hz;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] imm_alu;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // bit 0 of each word stays clear: x0 is never marked busy
    logic [31:0] busy      [NUM_THREADS];
    logic [31:0] busy_next [NUM_THREADS];

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign cmd    = decode_cmd(opcode);

    // Writebacks are ignored during reset and to x0; ALU data wins over load
    assign wb_fire = !rst && (bus.wb_alu_en || bus.wb_mem_en) && (bus.wb_rd != 5'd0);
    assign wb_data = bus.wb_alu_en ? bus.wb_alu_data : bus.wb_lmd_data;

    id_mt_regfile #(
        .XLEN        (XLEN),
        .NUM_THREADS (NUM_THREADS),
        .TID_W       (TID_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_fire),
        .wtid  (bus.wb_tid),
        .wrd   (bus.wb_rd),
        .wdata (wb_data),
        .rtid  (bus.in_tid),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rs1_rf),
        .rd2   (rs2_rf)
    );

    // Source-operand hazard: busy and not being released by this cycle's writeback
    always_comb begin
        rs1_hz = busy[bus.in_tid][rs1] &&
                 !(wb_fire && (bus.wb_tid == bus.in_tid) && (bus.wb_rd == rs1));
        rs2_hz = busy[bus.in_tid][rs2] &&
                 !(wb_fire && (bus.wb_tid == bus.in_tid) && (bus.wb_rd == rs2));
        hazard = bus.in_valid && (rs1_hz || (uses_rs2(opcode) && rs2_hz));
    end

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
    assign accept       = !rst && bus.in_valid && bus.in_ready;

    // Scoreboard update: clear on writeback, then set on issue so set wins
    // NOTE: every variable gets its default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        busy_next = busy;
        if (wb_fire) begin
            busy_next[bus.wb_tid][bus.wb_rd] = 1'b0;
        end
        if (accept && writes_rd(opcode) && (rd != 5'd0)) begin
            busy_next[bus.in_tid][rd] = 1'b1;
        end
    end

    // Immediates and operand values as presented to execute
    always_comb begin
        imm     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        imm_alu = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
        if (opcode == OP_STORE) begin
            imm_alu[4:0] = bus.in_instr[11:7];
        end
        rs1_val = rs1_rf;
        rs2_val = rs2_rf;
        if (cmd == OTHER) begin
            rs1_val = {{(XLEN-1){1'b0}}, 1'b1};
            rs2_val = '0;
        end
    end

    // Busy-bit state; reset drops every pending destination
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                busy[t] <= '0;
            end
        end else begin
            busy <= busy_next;
        end
    end

    // Output register: load on accept, drain on out_ready, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid    <= 1'b0;
            bus.out_opcode   <= '0;
            bus.out_cmd_type <= MEM;
            bus.out_rd       <= '0;
            bus.out_tid      <= '0;
            bus.out_imm      <= '0;
            bus.out_imm_alu  <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
            bus.out_pc       <= '0;
            bus.out_instr    <= '0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            bus.out_opcode   <= opcode;
            bus.out_cmd_type <= cmd;
            bus.out_rd       <= rd;
            bus.out_tid      <= bus.in_tid;
            bus.out_imm      <= imm;
            bus.out_imm_alu  <= imm_alu;
            bus.out_rs1_data <= rs1_val;
            bus.out_rs2_data <= rs2_val;
            bus.out_pc       <= bus.in_pc;
            bus.out_instr    <= bus.in_instr;
        end else if (bus.out_ready) begin
            bus.out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_decode_mt.sv
// Bench for id_decode_mt: a vector table plus hand-written multi-cycle
// sequences; expected outputs are queued on accept and compared on transfer.
module tb_id_decode_mt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  tid;
        logic [1:0]  cmd;
        logic [31:0] imm;
        logic [31:0] imm_alu;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    typedef struct {
        logic        alu_en;
        logic        mem_en;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic [4:0]  rd;
        logic [1:0]  tid;
    } wb_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_miss;
    exp_t sb [$];
    exp_t mon_e;
    exp_t vec [8];
    exp_t idle_e;
    exp_t e1, e2, e3;
    wb_t  no_wb;

    id_decode_mt_if #(.XLEN(32), .NUM_THREADS(4)) bus ();

    id_decode_mt #(.XLEN(32), .NUM_THREADS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] instr, input int tid, input logic [1:0] cmd,
                                input logic [31:0] imm, input logic [31:0] imm_alu,
                                input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        e.instr   = instr;
        e.pc      = ~instr;
        e.tid     = tid[1:0];
        e.cmd     = cmd;
        e.imm     = imm;
        e.imm_alu = imm_alu;
        e.rs1     = rs1;
        e.rs2     = rs2;
        return e;
    endfunction

    function automatic wb_t mk_wb(input logic alu_en, input logic mem_en, input logic [31:0] alu,
                                  input logic [31:0] lmd, input logic [4:0] rd, input int tid);
        wb_t w;
        w.alu_en = alu_en;
        w.mem_en = mem_en;
        w.alu    = alu;
        w.lmd    = lmd;
        w.rd     = rd;
        w.tid    = tid[1:0];
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_wb(input wb_t w);
        bus.wb_alu_en   = w.alu_en;
        bus.wb_mem_en   = w.mem_en;
        bus.wb_alu_data = w.alu;
        bus.wb_lmd_data = w.lmd;
        bus.wb_rd       = w.rd;
        bus.wb_tid      = w.tid;
    endtask

    // One cycle of stimulus: drive at negedge, sample in_ready 1 ns later.
    // exp_ready < 0 means in_ready is not checked this cycle.
    task automatic drive(input logic v, input exp_t e, input wb_t w, input logic ordy,
                         input int exp_ready);
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = v;
        bus.in_instr  = e.instr;
        bus.in_pc     = e.pc;
        bus.in_tid    = e.tid;
        bus.out_ready = ordy;
        apply_wb(w);
        #1;
        if (exp_ready >= 0) check("in_ready", {63'd0, bus.in_ready}, 64'(exp_ready));
        if (v && bus.in_ready) sb.push_back(e);
    endtask

    // Reset for two edges with an optional writeback that must be ignored
    task automatic do_reset(input wb_t w);
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        apply_wb(w);
        @(negedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_imm", {32'd0, bus.out_imm}, 64'd0);
        check("rst_out_rs1", {32'd0, bus.out_rs1_data}, 64'd0);
        check("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        sb.delete();
    endtask

    // Output monitor: a transfer happens at the next posedge when valid && ready
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_miss++;
                $display("FAIL unexpected_output: got instr %0h expected none", bus.out_instr);
            end else begin
                mon_e = sb.pop_front();
                check("out_instr", {32'd0, bus.out_instr}, {32'd0, mon_e.instr});
                check("out_pc", {32'd0, bus.out_pc}, {32'd0, mon_e.pc});
                check("out_tid", {62'd0, bus.out_tid}, {62'd0, mon_e.tid});
                check("out_opcode", {57'd0, bus.out_opcode}, {57'd0, mon_e.instr[6:0]});
                check("out_rd", {59'd0, bus.out_rd}, {59'd0, mon_e.instr[11:7]});
                check("out_cmd_type", {62'd0, bus.out_cmd_type}, {62'd0, mon_e.cmd});
                check("out_imm", {32'd0, bus.out_imm}, {32'd0, mon_e.imm});
                check("out_imm_alu", {32'd0, bus.out_imm_alu}, {32'd0, mon_e.imm_alu});
                check("out_rs1_data", {32'd0, bus.out_rs1_data}, {32'd0, mon_e.rs1});
                check("out_rs2_data", {32'd0, bus.out_rs2_data}, {32'd0, mon_e.rs2});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_miss   = 0;
        rst      = 1'b1;
        no_wb    = mk_wb(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0);
        idle_e   = mk(32'd0, 0, 2'b11, 32'd0, 32'd0, 32'd0, 32'd0);
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.in_tid    = '0;
        bus.out_ready = 1'b0;
        apply_wb(no_wb);

        // Thread 3 vectors; x1=0x11, x2=0x22, x10=0xDEADBEEF preloaded below
        vec[0] = mk(32'h00208033, 3, 2'b01, 32'h0,        32'h2,        32'h11,       32'h22); // add x0,x1,x2
        vec[1] = mk(32'hFFF08013, 3, 2'b01, 32'hFFFFFFE0, 32'hFFFFFFFF, 32'h11,       32'h0);  // addi x0,x1,-1
        vec[2] = mk(32'h0020A423, 3, 2'b00, 32'h8,        32'h8,        32'h11,       32'h22); // sw x2,8(x1)
        vec[3] = mk(32'hFE202E23, 3, 2'b00, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h22); // sw x2,-4(x0)
        vec[4] = mk(32'h008000EF, 3, 2'b11, 32'h1,        32'h8,        32'h1,        32'h0);  // jal
        vec[5] = mk(32'h00208063, 3, 2'b10, 32'h0,        32'h2,        32'h11,       32'h22); // beq x1,x2
        vec[6] = mk(32'hFFC52003, 3, 2'b00, 32'hFFFFFFE0, 32'hFFFFFFFC, 32'hDEADBEEF, 32'h0);  // lw x0,-4(x10)
        vec[7] = mk(32'h12345037, 3, 2'b11, 32'h120,      32'h123,      32'h1,        32'h0);  // lui

        do_reset(no_wb);

        // Writeback then dependent read in the following cycle
        drive(1'b0, idle_e, mk_wb(1'b1, 1'b0, 32'd18, 32'd0, 5'd5, 0), 1'b1, 1);
        drive(1'b1, mk(32'h000283B3, 0, 2'b01, 32'h7, 32'h0, 32'd18, 32'h0), no_wb, 1'b1, 1);

        // Same-cycle bypass on thread 1
        drive(1'b1, mk(32'h00018013, 1, 2'b01, 32'h0, 32'h0, 32'h9, 32'h0),
              mk_wb(1'b1, 1'b0, 32'h9, 32'h0, 5'd3, 1), 1'b1, 1);

        // Load-use stall on thread 0, other thread slips through
        drive(1'b1, mk(32'h00002203, 0, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0), no_wb, 1'b1, 1);
        e1 = mk(32'h00420333, 0, 2'b01, 32'h6, 32'h4, 32'h55, 32'h55);
        drive(1'b1, e1, no_wb, 1'b1, 0);
        drive(1'b1, e1, no_wb, 1'b1, 0);
        drive(1'b1, mk(32'h00500013, 2, 2'b01, 32'h0, 32'h5, 32'h0, 32'h0), no_wb, 1'b1, 1);
        drive(1'b1, e1, no_wb, 1'b1, 0);
        drive(1'b1, e1, mk_wb(1'b0, 1'b1, 32'h0, 32'h55, 5'd4, 0), 1'b1, 1);

        // ALU writeback wins over load data; x0 writes are dropped
        drive(1'b0, idle_e, mk_wb(1'b1, 1'b1, 32'hA, 32'hB, 5'd9, 2), 1'b1, -1);
        drive(1'b1, mk(32'h00048013, 2, 2'b01, 32'h0, 32'h0, 32'hA, 32'h0), no_wb, 1'b1, 1);
        drive(1'b1, mk(32'h00000013, 2, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0),
              mk_wb(1'b1, 1'b0, 32'h77, 32'h0, 5'd0, 2), 1'b1, 1);

        // Set and clear of the same busy bit in one cycle: set wins
        drive(1'b1, mk(32'h00100413, 2, 2'b01, 32'h8, 32'h1, 32'h0, 32'h0),
              mk_wb(1'b1, 1'b0, 32'h3, 32'h0, 5'd8, 2), 1'b1, 1);
        e2 = mk(32'h00040013, 2, 2'b01, 32'h0, 32'h0, 32'h3C, 32'h0);
        drive(1'b1, e2, no_wb, 1'b1, 0);
        drive(1'b1, e2, mk_wb(1'b1, 1'b0, 32'h3C, 32'h0, 5'd8, 2), 1'b1, 1);

        // Thread 0 x7 is busy; thread 1 reading x7 must not stall
        drive(1'b1, mk(32'h00738033, 1, 2'b01, 32'h0, 32'h7, 32'h0, 32'h0), no_wb, 1'b1, 1);

        // Preload thread 3 and run the vector table back to back
        drive(1'b0, idle_e, mk_wb(1'b1, 1'b0, 32'h11, 32'h0, 5'd1, 3), 1'b1, -1);
        drive(1'b0, idle_e, mk_wb(1'b0, 1'b1, 32'h0, 32'h22, 5'd2, 3), 1'b1, -1);
        drive(1'b0, idle_e, mk_wb(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd10, 3), 1'b1, -1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vec[i], no_wb, 1'b1, 1);
        end
        drive(1'b0, idle_e, no_wb, 1'b1, -1);

        // Back-pressure: held output, stalled input, exactly one transfer
        e1 = mk(32'h00008013, 3, 2'b01, 32'h0, 32'h0, 32'h11, 32'h0);
        e2 = mk(32'h00010013, 3, 2'b01, 32'h0, 32'h0, 32'h22, 32'h0);
        drive(1'b1, e1, no_wb, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, e2, no_wb, 1'b0, 0);
            check("held_valid", {63'd0, bus.out_valid}, 64'd1);
            check("held_instr", {32'd0, bus.out_instr}, {32'd0, e1.instr});
            check("held_rs1", {32'd0, bus.out_rs1_data}, 64'h11);
        end
        drive(1'b1, e2, no_wb, 1'b1, 1);
        drive(1'b0, idle_e, no_wb, 1'b1, -1);
        drive(1'b0, idle_e, no_wb, 1'b1, -1);

        // Reset while an output is held and x12 is busy; writeback during reset ignored
        e3 = mk(32'h00208633, 3, 2'b01, 32'hC, 32'h2, 32'h11, 32'h22);
        drive(1'b1, e3, no_wb, 1'b0, 1);
        drive(1'b1, e2, no_wb, 1'b0, 0);
        do_reset(mk_wb(1'b1, 1'b0, 32'h99, 32'h0, 5'd13, 3));
        drive(1'b1, mk(32'h00C60033, 3, 2'b01, 32'h0, 32'hC, 32'h0, 32'h0), no_wb, 1'b1, 1);
        drive(1'b1, mk(32'h00068013, 3, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0), no_wb, 1'b1, 1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, idle_e, no_wb, 1'b1, -1);
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
